// File: rtl/rpn_stack_alu.sv
// RPN calculator datapath: 8-bit signed operand stack with a
// multi-cycle add/sub/mul/swap sequencer and sticky error status.
module rpn_stack_alu #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       push,
  input  logic       pop,
  input  logic       op_go,
  input  logic [1:0] op_sel,
  output logic [7:0] top,
  output logic       top_valid,
  output logic [4:0] count,
  output logic       busy,
  output logic       err_empty,
  output logic       err_full,
  output logic       err_ovf
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, EXEC, MUL, WB
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  state_t state, state_nx;

  logic [7:0]  stk [DEPTH];
  logic [7:0]  a_r, b_r, res_r;
  logic [7:0]  ma_r, mb_r;
  logic [1:0]  sel_r;
  logic        ovf_r;
  logic [3:0]  it_r;
  logic [15:0] acc_r;

  logic          idle;
  logic          acc_push, acc_pop, acc_op;
  logic          can_push, can_pop, can_op;
  logic [AW-1:0] i_new, i_top, i_nos;
  logic [7:0]    sum, dif;
  logic [7:0]    ex_res;
  logic          ex_ovf;
  logic [15:0]   part, prod;
  logic          mul_ovf;

  assign idle     = (state == IDLE);
  assign acc_push = idle & push;
  assign acc_pop  = idle & ~push & pop;
  assign acc_op   = idle & ~push & ~pop & op_go;
  assign can_push = (count < 5'(DEPTH));
  assign can_pop  = (count != 5'd0);
  assign can_op   = (count >= 5'd2);

  assign i_new = AW'(count);
  assign i_top = AW'(count - 5'd1);
  assign i_nos = AW'(count - 5'd2);

  assign top_valid = (count != 5'd0);
  assign busy      = ~idle;

  assign sum = a_r + b_r;
  assign dif = a_r - b_r;

  always_comb begin
    ex_res = 8'd0;
    ex_ovf = 1'b0;
    unique case (sel_r)
      OP_ADD: begin
        ex_res = sum;
        ex_ovf = (a_r[7] == b_r[7]) && (sum[7] != a_r[7]);
      end
      OP_SUB: begin
        ex_res = dif;
        ex_ovf = (a_r[7] != b_r[7]) && (dif[7] != a_r[7]);
      end
      default: begin
        ex_res = 8'd0;
        ex_ovf = 1'b0;
      end
    endcase
  end

  // Magnitude shift-add; the sign is applied once the loop is done.
  assign part = mb_r[it_r[2:0]] ? ({8'd0, ma_r} << it_r[2:0]) : 16'd0;
  assign prod = (a_r[7] ^ b_r[7]) ? -acc_r : acc_r;
  assign mul_ovf = ~((&prod[15:7]) | ~(|prod[15:7]));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (acc_op && can_op) state_nx = LOAD;
      LOAD:    state_nx = (sel_r == OP_MUL) ? MUL : EXEC;
      EXEC:    state_nx = WB;
      MUL:     if (it_r == 4'd8) state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 5'd0;
      top       <= 8'd0;
      err_empty <= 1'b0;
      err_full  <= 1'b0;
      err_ovf   <= 1'b0;
      a_r       <= 8'd0;
      b_r       <= 8'd0;
      res_r     <= 8'd0;
      ma_r      <= 8'd0;
      mb_r      <= 8'd0;
      sel_r     <= 2'd0;
      ovf_r     <= 1'b0;
      it_r      <= 4'd0;
      acc_r     <= 16'd0;
    end else begin
      state <= state_nx;
      if (acc_push | acc_pop | acc_op) begin
        err_empty <= 1'b0;
        err_full  <= 1'b0;
        err_ovf   <= 1'b0;
      end
      if (acc_push) begin
        if (can_push) begin
          count <= count + 5'd1;
          top   <= din;
        end else begin
          err_full <= 1'b1;
        end
      end
      if (acc_pop) begin
        if (can_pop) begin
          count <= count - 5'd1;
          top   <= (count > 5'd1) ? stk[i_nos] : 8'd0;
        end else begin
          err_empty <= 1'b1;
        end
      end
      if (acc_op) begin
        if (can_op) begin
          a_r   <= stk[i_nos];
          b_r   <= stk[i_top];
          sel_r <= op_sel;
        end else begin
          err_empty <= 1'b1;
        end
      end
      if (state == LOAD) begin
        ma_r  <= a_r[7] ? -a_r : a_r;
        mb_r  <= b_r[7] ? -b_r : b_r;
        acc_r <= 16'd0;
        it_r  <= 4'd0;
      end
      if (state == EXEC) begin
        res_r <= ex_res;
        ovf_r <= ex_ovf;
      end
      if (state == MUL) begin
        if (it_r != 4'd8) begin
          acc_r <= acc_r + part;
          it_r  <= it_r + 4'd1;
        end else begin
          res_r <= prod[7:0];
          ovf_r <= mul_ovf;
        end
      end
      if (state == WB) begin
        err_ovf <= ovf_r;
        if (sel_r == OP_SWAP) begin
          top <= a_r;
        end else begin
          top   <= res_r;
          count <= count - 5'd1;
        end
      end
    end
  end

  // Stack storage needs no reset; writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (acc_push && can_push) stk[i_new] <= din;
      if (state == WB) begin
        if (sel_r == OP_SWAP) begin
          stk[i_nos] <= b_r;
          stk[i_top] <= a_r;
        end else begin
          stk[i_nos] <= res_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_rpn_stack_alu.sv
// Scoreboard bench for rpn_stack_alu: directed commands queue their
// expected response; a negedge monitor compares whenever one appears.
module tb_rpn_stack_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'd0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       op_go = 1'b0;
  logic [1:0] op_sel = 2'd0;
  logic [7:0] top;
  logic       top_valid;
  logic [4:0] count;
  logic       busy;
  logic       err_empty;
  logic       err_full;
  logic       err_ovf;

  rpn_stack_alu #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop),
    .op_go(op_go), .op_sel(op_sel), .top(top), .top_valid(top_valid),
    .count(count), .busy(busy), .err_empty(err_empty),
    .err_full(err_full), .err_ovf(err_ovf)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] top;
    logic [4:0] cnt;
    logic       tv;
    int         blen;
    logic       ee;
    logic       ef;
    logic       eo;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int nresp = 0;

  task automatic expect_r(input logic [7:0] t, input int c, input int bl,
                          input logic ee, input logic ef, input logic eo);
    exp_t e;
    e.top  = t;
    e.cnt  = 5'(c);
    e.tv   = (c != 0);
    e.blen = bl;
    e.ee   = ee;
    e.ef   = ef;
    e.eo   = eo;
    q.push_back(e);
  endtask

  task automatic judge(input int bl);
    exp_t e;
    nresp++;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_resp #%0d top=%h count=%0d required none",
               nresp, top, count);
    end else begin
      e = q.pop_front();
      checks++;
      if ({top, count, top_valid, busy} !== {e.top, e.cnt, e.tv, 1'b0}) begin
        failures++;
        $display("FAIL state #%0d top=%h count=%0d tv=%b busy=%b required top=%h count=%0d tv=%b busy=0",
                 nresp, top, count, top_valid, busy, e.top, e.cnt, e.tv);
      end
      checks++;
      if ({err_empty, err_full, err_ovf} !== {e.ee, e.ef, e.eo}) begin
        failures++;
        $display("FAIL flags #%0d empty/full/ovf=%b%b%b required %b%b%b",
                 nresp, err_empty, err_full, err_ovf, e.ee, e.ef, e.eo);
      end
      checks++;
      if (bl != e.blen) begin
        failures++;
        $display("FAIL busy_len #%0d got=%0d required=%0d", nresp, bl, e.blen);
      end
    end
  endtask

  logic prev_rst = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_cmd = 1'b0;
  int   blen = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (!prev_rst) judge(0);
      blen = 0;
    end else if (busy) begin
      blen++;
    end else if (prev_busy) begin
      judge(blen);
      blen = 0;
    end else if (prev_cmd) begin
      judge(0);
    end
    prev_cmd  = !rst && (push | pop | op_go) && !busy;
    prev_rst  = rst;
    prev_busy = busy;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic p, input logic po, input logic g,
                     input logic [1:0] s, input logic [7:0] d);
    push   = p;
    pop    = po;
    op_go  = g;
    op_sel = s;
    din    = d;
    cyc();
    push  = 1'b0;
    pop   = 1'b0;
    op_go = 1'b0;
  endtask

  task automatic psh(input logic [7:0] d, input int c);
    expect_r(d, c, 0, 1'b0, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 2'd0, d);
  endtask

  task automatic pp(input logic [7:0] t, input int c, input logic ee);
    expect_r(t, c, 0, ee, 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic op(input logic [1:0] s, input logic [7:0] t, input int c,
                    input int bl, input logic ee, input logic eo);
    expect_r(t, c, bl, ee, 1'b0, eo);
    cmd(1'b0, 1'b0, 1'b1, s, 8'd0);
    repeat (12) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    expect_r(8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    psh(8'd5, 1);
    psh(8'd3, 2);
    op(2'b00, 8'd8, 1, 3, 1'b0, 1'b0);

    psh(8'd100, 2);
    psh(8'd50, 3);
    op(2'b00, 8'h96, 2, 3, 1'b0, 1'b1);
    psh(8'd7, 3);

    psh(8'hF4, 4);
    psh(8'd11, 5);
    op(2'b10, 8'h7C, 4, 11, 1'b0, 1'b1);
    psh(8'hF8, 5);
    psh(8'hF0, 6);
    op(2'b10, 8'h80, 5, 11, 1'b0, 1'b1);
    psh(8'hF0, 6);
    psh(8'h08, 7);
    op(2'b10, 8'h80, 6, 11, 1'b0, 1'b0);

    psh(8'd9, 7);
    psh(8'd2, 8);
    op(2'b01, 8'd7, 7, 3, 1'b0, 1'b0);
    psh(8'd2, 8);
    op(2'b11, 8'd7, 8, 3, 1'b0, 1'b0);
    pp(8'd2, 7, 1'b0);

    psh(8'h11, 8);
    expect_r(8'h11, 8, 0, 1'b0, 1'b1, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 2'd0, 8'h22);
    pp(8'h02, 7, 1'b0);
    pp(8'h80, 6, 1'b0);
    pp(8'h80, 5, 1'b0);
    pp(8'h7C, 4, 1'b0);
    pp(8'h07, 3, 1'b0);
    pp(8'h96, 2, 1'b0);
    pp(8'h08, 1, 1'b0);
    pp(8'h00, 0, 1'b0);
    pp(8'h00, 0, 1'b1);

    psh(8'h33, 1);
    op(2'b00, 8'h33, 1, 0, 1'b1, 1'b0);

    expect_r(8'h44, 2, 0, 1'b0, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b1, 2'b00, 8'h44);
    repeat (4) cyc();

    expect_r(8'h8C, 1, 11, 1'b0, 1'b0, 1'b1);
    cmd(1'b0, 1'b0, 1'b1, 2'b10, 8'd0);
    repeat (4) cyc();
    cmd(1'b1, 1'b0, 1'b0, 2'd0, 8'h66);
    repeat (8) cyc();

    psh(8'h05, 2);
    expect_r(8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 2'b10, 8'd0);
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    psh(8'h12, 1);
    repeat (3) cyc();

    for (int i = 0; i < 50 && q.size() != 0; i++) cyc();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
